univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal shift register, the multi-bit successor to the lab D flip-flop. Each cycle it can hold, load, clear, shift, rotate or arithmetic-shift its contents. A burst engine performs a programmed number of shifts autonomously, with Busy/Done status. It serves as the storage and shifting element for later serial/parallel conversion and multiply/divide labs.

## Interface

Parameters:
- WIDTH, default 8: register width in bits; must be >= 2.
- CNT_W, default 4: width of the burst shift count.

Ports:
- Clock  input  1  single system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- Mode  input  3  operation select (encoding below).
- D  input  WIDTH  parallel load data.
- SinR  input  1  serial input entering the MSB on shift right.
- SinL  input  1  serial input entering the LSB on shift left.
- Start  input  1  request a burst of Count operations of the shift-type Mode.
- Count  input  CNT_W  number of burst operations (0..2^CNT_W-1).
- Q  output  WIDTH  register contents.
- SoutR  output  1  combinational Q[0] (shift-right serial out).
- SoutL  output  1  combinational Q[WIDTH-1] (shift-left serial out).
- Busy  output  1  high while a burst is executing.
- Done  output  1  one-cycle pulse when a burst completes.

## Operation

Mode encoding (applied at a rising edge):
- 000 hold: Q unchanged.
- 001 shift right: Q <= {SinR, Q[WIDTH-1:1]}.
- 010 shift left: Q <= {Q[WIDTH-2:0], SinL}.
- 011 load: Q <= D.
- 100 rotate right: Q <= {Q[0], Q[WIDTH-1:1]}.
- 101 rotate left: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
- 110 arithmetic shift right: Q <= {Q[WIDTH-1], Q[WIDTH-1:1]}.
- 111 clear: Q <= 0.

The shift-type modes are 001, 010, 100, 101 and 110.

FSM with two states, IDLE and BURST, plus a remaining-count register rem (CNT_W bits).

IDLE:
- Start=0: Mode is executed once per edge (single-step).
- Start=1 with a shift-type Mode and Count != 0:
  - latch the mode; rem <= Count.
  - go to BURST.
  - Q is unchanged on this edge.
- Start=1 with Count == 0 and a shift-type Mode: Q unchanged, Done <= 1, stay in IDLE.
- Start=1 with a non-shift Mode: Start is ignored and the Mode executes as a single step.

BURST:
- Each edge applies the latched mode and decrements rem.
- SinR/SinL are sampled live on every burst edge.
- Mode, D, Start and Count are ignored for the whole burst.
- On the edge where rem == 1: perform the final shift, go to IDLE, Done <= 1.

Outputs and reset:
- Busy = (state == BURST), registered.
- Done is high for exactly one cycle; otherwise it is 0.
- Reset asserted: Q=0, Busy=0, Done=0, rem=0, state=IDLE. This takes effect asynchronously, including mid-burst. A burst interrupted by Reset does not pulse Done.

## Timing

- Single-step latency: 1 edge. Q reflects the operation after the edge.
- Burst of N (N>=1):
  - Start is sampled at edge 0.
  - Busy is high from after edge 0 until after edge N.
  - Shifts occur at edges 1..N.
  - Done is high for the cycle following edge N.
  - Busy is low in the same cycle that Done is high.
  - A new Start is accepted in the Done cycle, so back-to-back bursts are legal.
- Start with Count=0: Done is high for the cycle after the start edge; Busy stays 0.
- SoutR/SoutL follow Q combinationally with no extra latency.
- The deassertion of Reset is synchronous to Clock by system design. The block adds no synchroniser.

## Test plan

All scenarios use WIDTH=8, CNT_W=4.

1. Reset=1 (no clock edge) -> Q=00, Busy=0, Done=0. Release Reset; Mode=011, D=A5 for one edge -> Q=A5, SoutR=1, SoutL=1.
2. Single-step shifts:
   - Q=A5; Mode=001, SinR=1, one edge -> Q=D2.
   - Then Mode=010, SinL=0, one edge -> Q=A4.
   - Then Mode=111 -> Q=00.
3. Burst rotate left: Q=81; Mode=101, Start=1, Count=3 for one edge -> Q stays 81 with Busy=1. Next three edges -> Q=03, 06, 0C. Then Busy=0 and Done=1 for exactly one cycle. Changing Mode or D during the burst has no effect.
4. Burst arithmetic shift right: Q=80; Mode=110, Start=1, Count=4 -> Q=C0, E0, F0, F8. Done pulses once. An immediate second Start with Count=1 in the Done cycle -> Q=FC.
5. Reset mid-burst: Q=0F; rotate-right burst with Count=10. After 2 shifts, assert Reset between edges -> Q=00, Busy=0 without a clock edge; no Done pulse follows. After release, Mode=000 keeps Q=00.
6. Edge cases:
   - Start=1, Count=0, Mode=001 -> Q unchanged, Busy stays 0, Done pulses one cycle.
   - Start=1, Mode=011, D=3C -> Q=3C after one edge, Busy stays 0, no Done.

Source files
------------

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register with an autonomous
// burst engine. Single-step ops execute every edge in IDLE; a Start with a
// shift-type mode and nonzero Count runs Count shifts, then pulses Done.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SinR,
  input  logic             SinL,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  output logic [WIDTH-1:0] Q,
  output logic             SoutR,
  output logic             SoutL,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  state_t           state, state_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic [2:0]       mode_lat, mode_lat_n;
  logic [WIDTH-1:0] q_n;
  logic             done_n;
  logic             start_shift;

  // One register update for a given mode; SinR/SinL are always the live inputs.
  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] m,
                                                input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] d,
                                                input logic sr,
                                                input logic sl);
    case (m)
      M_HOLD:  apply_op = q;
      M_SHR:   apply_op = {sr, q[WIDTH-1:1]};
      M_SHL:   apply_op = {q[WIDTH-2:0], sl};
      M_LOAD:  apply_op = d;
      M_ROR:   apply_op = {q[0], q[WIDTH-1:1]};
      M_ROL:   apply_op = {q[WIDTH-2:0], q[WIDTH-1]};
      M_ASR:   apply_op = {q[WIDTH-1], q[WIDTH-1:1]};
      M_CLR:   apply_op = '0;
      default: apply_op = q;
    endcase
  endfunction

  // Start only launches a burst for the shift-type modes; load/hold/clear ignore it.
  assign start_shift = Start && (Mode == M_SHR || Mode == M_SHL || Mode == M_ROR ||
                                 Mode == M_ROL || Mode == M_ASR);

  // Next-state, next-Q and Done pulse.
  always_comb begin
    state_n    = state;
    rem_n      = rem;
    mode_lat_n = mode_lat;
    q_n        = Q;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        if (start_shift) begin
          // Q holds on the start edge; the shifts begin on the next edge.
          if (Count != '0) begin
            state_n    = BURST;
            rem_n      = Count;
            mode_lat_n = Mode;
          end else begin
            done_n = 1'b1;
          end
        end else begin
          q_n = apply_op(Mode, Q, D, SinR, SinL);
        end
      end
      BURST: begin
        q_n   = apply_op(mode_lat, Q, D, SinR, SinL);
        rem_n = rem - 1'b1;
        if (rem == CNT_W'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State registers; reset aborts any burst without a Done pulse.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      rem      <= '0;
      mode_lat <= M_HOLD;
      Q        <= '0;
      Done     <= 1'b0;
    end else begin
      state    <= state_n;
      rem      <= rem_n;
      mode_lat <= mode_lat_n;
      Q        <= q_n;
      Done     <= done_n;
    end
  end

  assign Busy  = (state == BURST);
  assign SoutR = Q[0];
  assign SoutL = Q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8, CNT_W=4) with hand-computed expectations.
module tb_univ_shift_reg;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [2:0] Mode;
  logic [7:0] D;
  logic       SinR, SinL, Start;
  logic [3:0] Count;
  logic [7:0] Q;
  logic       SoutR, SoutL, Busy, Done;

  int checks = 0;
  int errors = 0;

  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .Mode(Mode), .D(D), .SinR(SinR), .SinL(SinL),
    .Start(Start), .Count(Count), .Q(Q), .SoutR(SoutR), .SoutL(SoutL),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [7:0] q, input logic b, input logic d);
    chk({tag, ".q"}, {24'h0, Q}, {24'h0, q});
    chk({tag, ".busy"}, {31'h0, Busy}, {31'h0, b});
    chk({tag, ".done"}, {31'h0, Done}, {31'h0, d});
  endtask

  initial begin
    Reset = 1'b1; Mode = 3'b000; D = 8'h00; SinR = 1'b0; SinL = 1'b0;
    Start = 1'b0; Count = 4'd0;
    #3;
    chk_st("reset", 8'h00, 1'b0, 1'b0);
    step();
    Reset = 1'b0;

    // 1. load
    Mode = 3'b011; D = 8'hA5; step();
    chk_st("load", 8'hA5, 1'b0, 1'b0);
    chk("soutr", {31'h0, SoutR}, 32'd1);
    chk("soutl", {31'h0, SoutL}, 32'd1);

    // 2. single steps
    Mode = 3'b001; SinR = 1'b1; step(); chk("shr", {24'h0, Q}, 32'hD2);
    Mode = 3'b010; SinL = 1'b0; step(); chk("shl", {24'h0, Q}, 32'hA4);
    Mode = 3'b111; step(); chk("clr", {24'h0, Q}, 32'h00);

    // 3. burst rotate-left x3, Mode/D scrambled during the burst
    Mode = 3'b011; D = 8'h81; step();
    Mode = 3'b101; Start = 1'b1; Count = 4'd3; step();
    chk_st("rol.start", 8'h81, 1'b1, 1'b0);
    Start = 1'b0; Mode = 3'b011; D = 8'hFF; Count = 4'd9;
    step(); chk_st("rol.1", 8'h03, 1'b1, 1'b0);
    Mode = 3'b111; Start = 1'b1;
    step(); chk_st("rol.2", 8'h06, 1'b1, 1'b0);
    Mode = 3'b000; Start = 1'b0;
    step(); chk_st("rol.3", 8'h0C, 1'b0, 1'b1);
    step(); chk_st("rol.after", 8'h0C, 1'b0, 1'b0);

    // 4. burst ASR x4, then back-to-back burst of 1 from the Done cycle
    Mode = 3'b011; D = 8'h80; step();
    Mode = 3'b110; Start = 1'b1; Count = 4'd4; step();
    chk_st("asr.start", 8'h80, 1'b1, 1'b0);
    Start = 1'b0;
    step(); chk_st("asr.1", 8'hC0, 1'b1, 1'b0);
    step(); chk_st("asr.2", 8'hE0, 1'b1, 1'b0);
    step(); chk_st("asr.3", 8'hF0, 1'b1, 1'b0);
    step(); chk_st("asr.4", 8'hF8, 1'b0, 1'b1);
    Start = 1'b1; Count = 4'd1; step();
    chk_st("b2b.start", 8'hF8, 1'b1, 1'b0);
    Start = 1'b0; Mode = 3'b000;
    step(); chk_st("b2b.1", 8'hFC, 1'b0, 1'b1);
    step(); chk_st("b2b.after", 8'hFC, 1'b0, 1'b0);

    // 5. reset mid-burst (rotate right, Count=10)
    Mode = 3'b011; D = 8'h0F; step();
    Mode = 3'b100; Start = 1'b1; Count = 4'd10; step();
    Start = 1'b0; Mode = 3'b000;
    step(); chk_st("ror.1", 8'h87, 1'b1, 1'b0);
    step(); chk_st("ror.2", 8'hC3, 1'b1, 1'b0);
    #2 Reset = 1'b1;
    #1 chk_st("midrst", 8'h00, 1'b0, 1'b0);
    step();
    Reset = 1'b0;
    step(); chk_st("postrst.1", 8'h00, 1'b0, 1'b0);
    step(); chk_st("postrst.2", 8'h00, 1'b0, 1'b0);

    // 6. Count=0 start, and Start with a non-shift mode
    Mode = 3'b011; D = 8'h5A; step();
    Mode = 3'b001; Start = 1'b1; Count = 4'd0; step();
    chk_st("cnt0", 8'h5A, 1'b0, 1'b1);
    Start = 1'b0; Mode = 3'b000; step();
    chk_st("cnt0.after", 8'h5A, 1'b0, 1'b0);
    Mode = 3'b011; D = 8'h3C; Start = 1'b1; Count = 4'd5; step();
    chk_st("ldstart", 8'h3C, 1'b0, 1'b0);
    Start = 1'b0; Mode = 3'b000; step();
    chk_st("ldstart.after", 8'h3C, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
